// File: rtl/inst_sram_resp_pkg.sv
// Shared CPU-side constants for the instruction SRAM responder.
package inst_sram_resp_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = WORD_W / NUM_LANES;

  localparam logic [WORD_W-1:0] BASE_DEFAULT = 32'h1c00_0000;

endpackage

// File: rtl/inst_sram_resp_sram_bytewr.sv
// Single-port, byte-enabled, read-first storage array. Contents are never reset.
module sram_bytewr
  import inst_sram_resp_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 rd_en,
  input  logic [NUM_LANES-1:0] we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Capture the pre-write word when asked, then apply the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (rd_en) begin
        rdata <= mem[addr];
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

endmodule

// File: rtl/inst_sram_resp.sv
// CPU instruction SRAM responder: address decode, CPU/backdoor-load arbitration,
// access counters and sticky error flags around a read-first byte-write array.
module inst_sram_resp
  import inst_sram_resp_pkg::*;
#(
  parameter int                ADDR_W = 12,
  parameter logic [WORD_W-1:0] BASE   = BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inst_sram_en,
  input  logic [NUM_LANES-1:0] inst_sram_we,
  input  logic [WORD_W-1:0]    inst_sram_addr,
  input  logic [WORD_W-1:0]    inst_sram_wdata,
  output logic [WORD_W-1:0]    inst_sram_rdata,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [WORD_W-1:0]    ld_data,
  output logic                 err_range,
  output logic                 err_align,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt
);

  // Window size in bytes, one bit wider so ADDR_W up to 30 does not overflow.
  localparam logic [WORD_W:0] WIN_BYTES = (WORD_W+1)'(1) << (ADDR_W + 2);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  logic [WORD_W-1:0]    offset;
  logic                 in_range;
  logic [ADDR_W-1:0]    cpu_idx;
  logic                 cpu_acc;
  logic                 cpu_rd;
  logic                 cpu_wr;

  logic                 mem_en;
  logic                 mem_rd;
  logic [NUM_LANES-1:0] mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_W-1:0]    mem_wdata;
  logic [WORD_W-1:0]    mem_q_p1;
  logic                 rd_vld_p1;

  assign offset   = inst_sram_addr - BASE;
  assign in_range = (inst_sram_addr >= BASE) && ({1'b0, offset} < WIN_BYTES);
  assign cpu_idx  = offset[ADDR_W+1:2];

  // Nothing is accepted while reset is asserted, so writes cannot slip through.
  assign cpu_acc  = inst_sram_en & resetn;
  assign cpu_rd   = cpu_acc & (inst_sram_we == '0);
  assign cpu_wr   = cpu_acc & (inst_sram_we != '0);
  assign ld_ready = ld_valid & ~inst_sram_en & resetn;

  // Steer the single array port: CPU first, backdoor load only on idle CPU cycles.
  always_comb begin
    mem_en    = 1'b0;
    mem_rd    = 1'b0;
    mem_we    = '0;
    mem_addr  = ld_addr;
    mem_wdata = ld_data;
    if (cpu_acc) begin
      mem_addr  = cpu_idx;
      mem_wdata = inst_sram_wdata;
      if (in_range) begin
        mem_en = 1'b1;
        mem_rd = 1'b1;
        mem_we = inst_sram_we;
      end
    end else if (ld_ready) begin
      mem_en = 1'b1;
      mem_we = '1;
    end
  end

  sram_bytewr #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .rd_en (mem_rd),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_q_p1)
  );

  // ---- stage p1: response select (array word for in-range, zero otherwise) ----
  // Idle cycles keep the last selection, and the array output holds, so rdata holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_vld_p1 <= 1'b0;
    end else if (cpu_acc) begin
      rd_vld_p1 <= in_range;
    end
  end

  assign inst_sram_rdata = rd_vld_p1 ? mem_q_p1 : '0;

  // Saturating counts of accepted CPU reads and writes, in or out of range.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (cpu_rd) rd_cnt <= sat_inc(rd_cnt);
      if (cpu_wr) wr_cnt <= sat_inc(wr_cnt);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_range <= 1'b0;
      err_align <= 1'b0;
    end else if (cpu_acc) begin
      if (!in_range)                   err_range <= 1'b1;
      if (inst_sram_addr[1:0] != 2'b0) err_align <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed scoreboard bench for inst_sram_resp (default ADDR_W=12, BASE=32'h1c00_0000).
module tb_inst_sram_resp;

  localparam int          ADDR_W = 12;
  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [31:0] BASE   = 32'h1c00_0000;

  logic              clk;
  logic              resetn;
  logic              inst_sram_en;
  logic [3:0]        inst_sram_we;
  logic [31:0]       inst_sram_addr;
  logic [31:0]       inst_sram_wdata;
  logic [31:0]       inst_sram_rdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;
  logic              err_range;
  logic              err_align;
  logic [31:0]       rd_cnt;
  logic [31:0]       wr_cnt;

  inst_sram_resp #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_addr         (ld_addr),
    .ld_data         (ld_data),
    .err_range       (err_range),
    .err_align       (err_align),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb [$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_rd = 0;
  logic [31:0] exp_wr = 0;
  logic        exp_er = 1'b0;
  logic        exp_ea = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".rd_cnt"},    rd_cnt,    exp_rd);
    check({tag, ".wr_cnt"},    wr_cnt,    exp_wr);
    check({tag, ".err_range"}, err_range, exp_er);
    check({tag, ".err_align"}, err_align, exp_ea);
  endtask

  // Backdoor load of one word on a cycle with the CPU idle.
  task automatic ld_word(input int idx, input logic [31:0] data);
    inst_sram_en = 1'b0;
    ld_valid     = 1'b1;
    ld_addr      = ADDR_W'(idx);
    ld_data      = data;
    #1;
    check("ld_ready_idle", ld_ready, 1'b1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    mdl[idx] = data;
  endtask

  // One CPU access: expected response is pushed at drive time, popped after the edge.
  task automatic cpu(input string tag, input logic [3:0] we, input logic [31:0] addr,
                     input logic [31:0] wdata);
    logic [31:0] off;
    logic [31:0] exp;
    bit          inr;
    int          idx;
    off = addr - BASE;
    inr = (addr >= BASE) && (off < 4 * DEPTH);
    idx = int'((off >> 2) & (DEPTH - 1));
    exp = inr ? mdl[idx] : 32'h0;
    sb.push_back(exp);
    if (we == 4'b0) exp_rd++; else exp_wr++;
    if (!inr) exp_er = 1'b1;
    if (addr[1:0] != 2'b0) exp_ea = 1'b1;
    if (inr) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mdl[idx][i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    inst_sram_en    = 1'b1;
    inst_sram_we    = we;
    inst_sram_addr  = addr;
    inst_sram_wdata = wdata;
    #1;
    check({tag, ".ld_ready"}, ld_ready, 1'b0);
    @(posedge clk);
    #1;
    inst_sram_en = 1'b0;
    inst_sram_we = 4'b0;
    check({tag, ".rdata"}, inst_sram_rdata, sb.pop_front());
    check_status(tag);
  endtask

  initial begin
    resetn          = 1'b0;
    inst_sram_en    = 1'b0;
    inst_sram_we    = 4'b0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    ld_valid        = 1'b1;
    ld_addr         = '0;
    ld_data         = 32'h0;

    // Reset state, with a pending load that must not be accepted.
    repeat (2) @(posedge clk);
    #1;
    check("reset.ld_ready", ld_ready, 1'b0);
    check("reset.rdata", inst_sram_rdata, 32'h0);
    check_status("reset");
    ld_valid = 1'b0;
    resetn   = 1'b1;

    // Backdoor load words 0..3, then read word 2.
    for (int i = 0; i < 4; i++) ld_word(i, 32'h1111_0000 + i);
    cpu("rd_word2", 4'b0000, 32'h1c00_0008, 32'h0);

    // Byte-lane write returns the old word; following read sees the merged word.
    cpu("wr_lanes", 4'b0101, 32'h1c00_0000, 32'hAABB_CCDD);
    check("merged_model", mdl[0], 32'h11BB_00DD);
    cpu("rd_merged", 4'b0000, 32'h1c00_0000, 32'h0);

    // Idle cycle holds the last read data.
    @(posedge clk);
    #1;
    check("idle_hold", inst_sram_rdata, 32'h11BB_00DD);

    // Out-of-range read below the window and write just past its top.
    cpu("rd_below", 4'b0000, 32'h1bff_fffc, 32'h0);
    cpu("wr_above", 4'b1111, 32'h1c00_4000, 32'hFFFF_FFFF);
    cpu("rd_after_oor_wr", 4'b0000, 32'h1c00_0000, 32'h0);

    // CPU burst blocks a pending load; load lands on the first idle cycle.
    ld_valid = 1'b1;
    ld_addr  = ADDR_W'(5);
    ld_data  = 32'h5555_5555;
    for (int i = 0; i < 3; i++) cpu("burst_rd", 4'b0000, 32'h1c00_0004, 32'h0);
    ld_word(5, 32'h5555_5555);
    cpu("rd_after_load", 4'b0000, 32'h1c00_0014, 32'h0);

    // Misaligned read indexes word 1.
    cpu("rd_misalign", 4'b0000, 32'h1c00_0006, 32'h0);

    // Reset asserted in the middle of a burst; writes during reset are blocked.
    inst_sram_en   = 1'b1;
    inst_sram_we   = 4'b0;
    inst_sram_addr = 32'h1c00_0004;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst.rdata", inst_sram_rdata, 32'h0);
    exp_rd = 0; exp_wr = 0; exp_er = 1'b0; exp_ea = 1'b0;
    check_status("async_rst");
    inst_sram_we    = 4'b1111;
    inst_sram_wdata = 32'hDEAD_BEEF;
    ld_valid        = 1'b1;
    ld_addr         = ADDR_W'(1);
    ld_data         = 32'hCAFE_F00D;
    #1;
    check("rst_hold.ld_ready", ld_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold.rdata", inst_sram_rdata, 32'h0);
    check_status("rst_hold");
    ld_valid     = 1'b0;
    inst_sram_en = 1'b0;
    inst_sram_we = 4'b0;
    resetn       = 1'b1;

    // First access after release is served and shows word 1 survived reset.
    cpu("post_reset_rd", 4'b0000, 32'h1c00_0004, 32'h0);
    check("post_reset_model", mdl[1], 32'h1111_0001);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
